// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator for the decode stage.
// One instruction in per valid/ready transfer; format, immediate and illegal flag
// come out one cycle later through a valid/ready port, optionally skid-buffered.
module imm_gen_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter bit          SIGN_EXT = 1'b1,
    parameter bit          SKID     = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : gen_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam bit Rv64 = (XLEN == 64);
    // Payload layout: {illegal, fmt, imm}
    localparam int unsigned PW = XLEN + 4;

    localparam logic [2:0] FmtNone = 3'd0;
    localparam logic [2:0] FmtI    = 3'd1;
    localparam logic [2:0] FmtS    = 3'd2;
    localparam logic [2:0] FmtB    = 3'd3;
    localparam logic [2:0] FmtU    = 3'd4;
    localparam logic [2:0] FmtJ    = 3'd5;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpImm32  = 7'b0011011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpOp32   = 7'b0111011;

    logic          fill;
    logic [2:0]    dec_fmt;
    logic          dec_ill;
    logic [63:0]   dec_imm64;
    logic [PW-1:0] dec_pl;

    logic          push, pop;
    logic          main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d;
    logic [PW-1:0] main_q, main_d, skid_q, skid_d;

    // Classify the opcode and build the extended immediate
    always_comb begin
        fill      = SIGN_EXT ? in_instr[31] : 1'b0;
        dec_fmt   = FmtNone;
        dec_ill   = 1'b0;
        dec_imm64 = '0;
        case (in_instr[6:0])
            OpLoad, OpFence, OpImm, OpJalr, OpSystem: dec_fmt = FmtI;
            OpImm32:  if (Rv64) dec_fmt = FmtI; else dec_ill = 1'b1;
            OpStore:  dec_fmt = FmtS;
            OpBranch: dec_fmt = FmtB;
            OpLui, OpAuipc: dec_fmt = FmtU;
            OpJal:    dec_fmt = FmtJ;
            OpOp:     dec_fmt = FmtNone;
            OpOp32:   if (!Rv64) dec_ill = 1'b1;
            // Also covers every word with instr[1:0] != 2'b11
            default:  dec_ill = 1'b1;
        endcase
        case (dec_fmt)
            FmtI: dec_imm64 = {{52{fill}}, in_instr[31:20]};
            FmtS: dec_imm64 = {{52{fill}}, in_instr[31:25], in_instr[11:7]};
            FmtB: dec_imm64 = {{51{fill}}, in_instr[31], in_instr[7], in_instr[30:25],
                               in_instr[11:8], 1'b0};
            FmtU: dec_imm64 = {{32{fill}}, in_instr[31:12], 12'b0};
            FmtJ: dec_imm64 = {{43{fill}}, in_instr[31], in_instr[19:12], in_instr[20],
                               in_instr[30:21], 1'b0};
            default: dec_imm64 = '0;
        endcase
        dec_pl = {dec_ill, dec_fmt, dec_imm64[XLEN-1:0]};
    end

    // in_ready: registered skid-free flag, or combinational pass-through when unbuffered
    always_comb begin
        if (SKID) in_ready = rdy_q & ~reset;
        else      in_ready = (~main_v_q | out_ready) & ~reset;
    end

    // Next-state for the output stage and (optionally) the skid stage
    always_comb begin
        push     = in_valid & in_ready;
        pop      = main_v_q & out_ready;
        main_v_d = main_v_q;
        main_d   = main_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        if (SKID) begin
            if (pop) begin
                if (skid_v_q) begin
                    // Older skid entry goes first to keep FIFO order
                    main_d   = skid_q;
                    skid_v_d = push;
                    if (push) skid_d = dec_pl;
                end else begin
                    main_v_d = push;
                    if (push) main_d = dec_pl;
                end
            end else if (push) begin
                if (main_v_q) begin
                    skid_v_d = 1'b1;
                    skid_d   = dec_pl;
                end else begin
                    main_v_d = 1'b1;
                    main_d   = dec_pl;
                end
            end
        end else begin
            if (push) begin
                main_v_d = 1'b1;
                main_d   = dec_pl;
            end else if (pop) begin
                main_v_d = 1'b0;
            end
        end
        rdy_d = ~skid_v_d;
    end

    // Stage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            main_v_q <= 1'b0;
            main_q   <= '0;
            skid_v_q <= 1'b0;
            skid_q   <= '0;
            rdy_q    <= 1'b1;
        end else begin
            main_v_q <= main_v_d;
            main_q   <= main_d;
            skid_v_q <= skid_v_d;
            skid_q   <= skid_d;
            rdy_q    <= rdy_d;
        end
    end

    // Output port view of the main stage
    always_comb begin
        out_valid                       = main_v_q;
        {out_illegal, out_fmt, out_imm} = main_q;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: three configurations driven from one stream.
//   u0: XLEN=32, sign-extend, skid   u1: XLEN=32, zero-extend, no skid
//   u2: XLEN=64, sign-extend, skid
module tb_imm_gen_pipe;

    typedef struct packed {
        logic        ill;
        logic [2:0]  fmt;
        logic [63:0] imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  vld;
    logic [31:0] in_instr;
    logic        out_ready;
    logic [2:0]  in_ready, out_valid, out_ill;
    logic [2:0]  fmt0, fmt1, fmt2;
    logic [31:0] imm0, imm1;
    logic [63:0] imm2;
    exp_t        act [3];

    exp_t q0[$], q1[$], q2[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1'b1), .SKID(1'b1)) u0 (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(in_ready[0]),
        .in_instr(in_instr), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_imm(imm0), .out_fmt(fmt0), .out_illegal(out_ill[0])
    );
    imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1'b0), .SKID(1'b0)) u1 (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(in_ready[1]),
        .in_instr(in_instr), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_imm(imm1), .out_fmt(fmt1), .out_illegal(out_ill[1])
    );
    imm_gen_pipe #(.XLEN(64), .SIGN_EXT(1'b1), .SKID(1'b1)) u2 (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_ready(in_ready[2]),
        .in_instr(in_instr), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_imm(imm2), .out_fmt(fmt2), .out_illegal(out_ill[2])
    );

    always_comb begin
        act[0] = {out_ill[0], fmt0, 32'h0, imm0};
        act[1] = {out_ill[1], fmt1, 32'h0, imm1};
        act[2] = {out_ill[2], fmt2, imm2};
    end

    task automatic chk(input string name, input logic [67:0] got, input logic [67:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic exp_t ex(input logic ill, input logic [2:0] fmt, input logic [63:0] imm);
        ex = '{ill: ill, fmt: fmt, imm: imm};
    endfunction

    // Offer one instruction to every instance; each expected value is queued when that
    // instance is seen to accept it.
    task automatic send(input logic [31:0] instr, input exp_t e0, input exp_t e1,
                        input exp_t e2);
        logic [2:0] take;
        in_instr = instr;
        vld      = 3'b111;
        for (int c = 0; c < 64 && vld != 3'b000; c++) begin
            take = 3'b000;
            @(negedge clk);
            if (vld[0] && in_ready[0]) begin q0.push_back(e0); take[0] = 1'b1; end
            if (vld[1] && in_ready[1]) begin q1.push_back(e1); take[1] = 1'b1; end
            if (vld[2] && in_ready[2]) begin q2.push_back(e2); take[2] = 1'b1; end
            @(posedge clk);
            #1;
            vld = vld & ~take;
        end
        chk("send_accept_timeout", {65'b0, vld}, 68'b0);
        vld = 3'b000;
    endtask

    task automatic drain();
        for (int c = 0; c < 64 && (q0.size() + q1.size() + q2.size()) != 0; c++)
            @(posedge clk);
        chk("drain_queues_empty", 68'(q0.size() + q1.size() + q2.size()), 68'd0);
        #1;
    endtask

    // Monitor: pop and compare on every output transfer; u0 payload must hold while stalled
    logic prev_stall = 1'b0;
    exp_t prev0;
    always @(negedge clk) begin : monitor
        exp_t e;
        logic have;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("u0_stall_stable", act[0], prev0);
            prev_stall = out_valid[0] & ~out_ready;
            prev0      = act[0];
            for (int k = 0; k < 3; k++) begin
                if (out_valid[k] && out_ready) begin
                    have = 1'b0;
                    e    = '0;
                    case (k)
                        0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
                        1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
                        default: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
                    endcase
                    chk($sformatf("u%0d_output_expected", k), {67'b0, have}, 68'd1);
                    if (have) chk($sformatf("u%0d_payload", k), act[k], e);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        n_fail++;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stim
        reset     = 1'b1;
        vld       = 3'b111;
        in_instr  = 32'hFFF00093;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready_low", {65'b0, in_ready}, 68'd0);
            chk("rst_out_valid_low", {65'b0, out_valid}, 68'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        vld   = 3'b000;
        @(negedge clk);
        chk("post_rst_in_ready", {65'b0, in_ready}, 68'h7);
        chk("post_rst_no_capture", {65'b0, out_valid}, 68'd0);
        chk("post_rst_u0_zero", act[0], 68'd0);
        chk("post_rst_u2_zero", act[2], 68'd0);
        @(posedge clk);
        #1;

        // addi x1,x0,-1 then one-cycle latency
        send(32'hFFF00093, ex(0, 1, 'hFFFFFFFF), ex(0, 1, 'h00000FFF),
             ex(0, 1, 64'hFFFFFFFFFFFFFFFF));
        @(negedge clk);
        chk("latency_one_cycle", {65'b0, out_valid}, 68'h7);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors
        send(32'hFE000EE3, ex(0, 3, 'hFFFFFFFC), ex(0, 3, 'h1FFC),
             ex(0, 3, 64'hFFFFFFFFFFFFFFFC));
        send(32'h7E002FA3, ex(0, 2, 'h7FF), ex(0, 2, 'h7FF), ex(0, 2, 'h7FF));
        send(32'h123452B7, ex(0, 4, 'h12345000), ex(0, 4, 'h12345000), ex(0, 4, 'h12345000));
        send(32'h800002B7, ex(0, 4, 'h80000000), ex(0, 4, 'h80000000),
             ex(0, 4, 64'hFFFFFFFF80000000));
        send(32'h00000000, ex(1, 0, 0), ex(1, 0, 0), ex(1, 0, 0));
        send(32'h0010009B, ex(1, 0, 0), ex(1, 0, 0), ex(0, 1, 1));
        send(32'h00B50533, ex(0, 0, 0), ex(0, 0, 0), ex(0, 0, 0));
        send(32'hFF9FF06F, ex(0, 5, 'hFFFFFFF8), ex(0, 5, 'h1FFFF8),
             ex(0, 5, 64'hFFFFFFFFFFFFFFF8));
        send(32'hFFF00092, ex(1, 0, 0), ex(1, 0, 0), ex(1, 0, 0));
        send(32'hFFFFF017, ex(0, 4, 'hFFFFF000), ex(0, 4, 'hFFFFF000),
             ex(0, 4, 64'hFFFFFFFFFFFFF000));
        send(32'h0000003B, ex(1, 0, 0), ex(1, 0, 0), ex(0, 0, 0));
        send(32'h80002083, ex(0, 1, 'hFFFFF800), ex(0, 1, 'h800),
             ex(0, 1, 64'hFFFFFFFFFFFFF800));
        drain();

        // Skid: stall the consumer while A, B, C are offered
        out_ready = 1'b0;
        fork
            begin
                send(32'h00001037, ex(0, 4, 'h1000), ex(0, 4, 'h1000), ex(0, 4, 'h1000));
                send(32'h00002037, ex(0, 4, 'h2000), ex(0, 4, 'h2000), ex(0, 4, 'h2000));
                send(32'h00003037, ex(0, 4, 'h3000), ex(0, 4, 'h3000), ex(0, 4, 'h3000));
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("skid_full_in_ready_low", {65'b0, in_ready}, 68'd0);
                chk("skid_main_holds_a", act[0], ex(0, 4, 'h1000));
                chk("skid_out_valid", {65'b0, out_valid}, 68'h7);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-stream discards held entries
        out_ready = 1'b0;
        send(32'h00004037, ex(0, 4, 'h4000), ex(0, 4, 'h4000), ex(0, 4, 'h4000));
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge clk);
        chk("midrst_out_valid_low", {65'b0, out_valid}, 68'd0);
        chk("midrst_in_ready_high", {65'b0, in_ready}, 68'h7);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("midrst_nothing_emitted", {65'b0, out_valid}, 68'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
